fetch_stage: RTL

//  Instruction fetch stage sitting directly upstream of the decode Controller.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: redirect-select encoding and fetch FSM states.
package fetch_pkg;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JMP = 2'd2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // Encoding 3 is reserved and behaves like sequential fetch.
    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == NPC_BR) || (sel == NPC_JMP);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head is read straight from the storage registers.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count_q != CW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response queue, redirect flush.
// Optional FETCH_STALL_CNT_EN adds the stall_cycles counter output.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    INST_BIT_WIDTH = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    PC_INC         = 4,
    parameter int                    QUEUE_DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                nextpc_mux,
    input  logic [ADDR_WIDTH-1:0]     branch_target,
    input  logic [ADDR_WIDTH-1:0]     jump_target,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [ADDR_WIDTH-1:0]     imem_addr,
    input  logic                      imem_rsp_valid,
    input  logic [INST_BIT_WIDTH-1:0] imem_rsp_data,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [INST_BIT_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0]     inst_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int IQW = INST_BIT_WIDTH + ADDR_WIDTH;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         drop_q, drop_d;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] target;
    logic                  credit_ok;
    logic                  accept;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         inflight_after;
    logic                  rsp_keep;
    logic                  inst_pop;

    logic [CW-1:0]         iq_count;
    logic [IQW-1:0]        iq_head;
    logic [ADDR_WIDTH-1:0] pcq_head;

    assign redirect = (state_q != BOOT) && is_redirect(nextpc_mux);
    assign target   = (nextpc_mux == NPC_BR) ? branch_target : jump_target;

    // Queued plus outstanding never exceeds the queue size, so every response has a slot.
    assign credit_ok      = ({1'b0, iq_count} + {1'b0, inflight}) < (CW + 1)'(QUEUE_DEPTH);
    assign imem_req_valid = (state_q == RUN) && credit_ok && !redirect;
    assign imem_addr      = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign inflight_after = inflight + CW'(accept) - CW'(imem_rsp_valid);

    assign rsp_keep = imem_rsp_valid && !redirect && (drop_q == '0);
    assign inst_pop = inst_valid && inst_ready;

    // Tags of outstanding requests; its occupancy is the in-flight count.
    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (accept),
        .push_data (pc_q),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .count     (inflight),
        .head      (pcq_head)
    );

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (IQW)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (reset),
        .push      (rsp_keep),
        .push_data ({imem_rsp_data, pcq_head}),
        .pop       (inst_pop),
        .flush     (redirect),
        .count     (iq_count),
        .head      (iq_head)
    );

    assign inst_valid = (iq_count != '0);
    assign inst       = inst_valid ? iq_head[IQW-1 -: INST_BIT_WIDTH] : '0;
    assign inst_pc    = inst_valid ? iq_head[ADDR_WIDTH-1:0] : '0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d    = target;
                    drop_d  = inflight_after;
                    state_d = (inflight_after != '0) ? FLUSH : RUN;
                end else if (accept) begin
                    pc_d = pc_q + ADDR_WIDTH'(PC_INC);
                end
            end
            FLUSH: begin
                // No requests here, so every outstanding response is wrong-path.
                if (redirect) begin
                    pc_d   = target;
                    drop_d = inflight_after;
                end else if (imem_rsp_valid && (drop_q != '0)) begin
                    drop_d = drop_q - CW'(1);
                end
                state_d = (drop_d == '0) ? RUN : FLUSH;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (inst_ready && !inst_valid && (state_q != BOOT) && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
